hero_write_arb: RTL

Round-robin arbiter that shares one hero write bus between `NUM_REQ` requesters. Each requester issues multi-beat `hero_write_t` transactions: zero or more `CYCLE_TYPE_VALID` beats, then one `CYCLE_TYPE_DONE` beat. The arbiter grants one requester at a time and holds that grant until the requester's DONE beat is accepted. It sits between the hero-bus producers and the single registered hero bus toward the bag.

---
 rtl/hero_write_arb_pkg.sv | 18 +
 rtl/hero_write_arb_if.sv | 21 ++
 rtl/hero_rr_pick.sv | 24 ++
 rtl/hero_write_arb.sv | 93 +++++++++
 4 files changed

// File: rtl/hero_write_arb_pkg.sv
// hero_write_arb_pkg: shared hero bus types and arbiter constants
package hero_write_arb_pkg;
  typedef enum logic [1:0] {
    CYCLE_TYPE_IDLE  = 2'd0,
    CYCLE_TYPE_VALID = 2'd1,
    CYCLE_TYPE_DONE  = 2'd2
  } CYCLE_TYPE_E;
  typedef struct packed {
    CYCLE_TYPE_E cycle_type;
    logic [31:0] data;
  } hero_write_t;
  localparam int HERO_ARB_NUM_REQ       = 4;
  localparam int HERO_ARB_NUM_REQ_WIDTH = $clog2(HERO_ARB_NUM_REQ);
  typedef enum logic {
    ARB,    // no lock held; next grant chosen round-robin from rr_ptr
    LOCKED  // owner holds the bus until its DONE beat or an idle timeout
  } HERO_ARB_STATE_E;
endpackage

// File: rtl/hero_write_arb_if.sv
// hero_write_arb_if: requester-side and downstream hero bus signals of the arbiter
interface hero_write_arb_if import hero_write_arb_pkg::*; #(
  parameter int NUM_REQ = HERO_ARB_NUM_REQ
);
  hero_write_t [NUM_REQ-1:0]   req_write;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          req_mask;
  hero_write_t                 out_write;
  logic                        out_ready;
  logic [$clog2(NUM_REQ)-1:0]  owner;
  logic                        owner_vld;
  logic                        timeout_err;
  modport master (
    output req_write, req_mask, out_ready,
    input  req_ready, out_write, owner, owner_vld, timeout_err
  );
  modport slave (
    input  req_write, req_mask, out_ready,
    output req_ready, out_write, owner, owner_vld, timeout_err
  );
endinterface

// File: rtl/hero_rr_pick.sv
// hero_rr_pick: first set candidate scanning upward from rr_ptr, modulo NUM_REQ
module hero_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         cand,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       pick_vld,
  output logic [$clog2(NUM_REQ)-1:0] pick_idx
);
  localparam int W = $clog2(NUM_REQ);
  int j;
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    j = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (cand[W'(j)]) begin
        pick_vld = 1'b1;
        pick_idx = W'(j);
      end
    end
  end
endmodule

// File: rtl/hero_write_arb.sv
// hero_write_arb: round-robin lock arbiter sharing one registered hero write bus
module hero_write_arb import hero_write_arb_pkg::*; #(
  parameter int NUM_REQ = HERO_ARB_NUM_REQ,
  parameter int TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst,
  hero_write_arb_if.slave bus
);
  localparam int W  = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  HERO_ARB_STATE_E    state, state_nxt;
  logic [W-1:0]       rr_ptr, rr_nxt, owner_nxt, pick_idx;
  logic [CW-1:0]      idle_cnt, idle_nxt;
  logic [NUM_REQ-1:0] cand, ready;
  logic               pick_vld, out_free, timeout_nxt;
  hero_write_t        owner_beat, load_beat;
  function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] v);
    return (v == W'(NUM_REQ - 1)) ? '0 : v + 1'b1;
  endfunction
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_REQ; i++)
      cand[i] = bus.req_mask[i] && (bus.req_write[i].cycle_type != CYCLE_TYPE_IDLE);
  end
  hero_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .cand     (cand),
    .rr_ptr   (rr_ptr),
    .pick_vld (pick_vld),
    .pick_idx (pick_idx)
  );
  assign out_free      = (bus.out_write.cycle_type == CYCLE_TYPE_IDLE) || bus.out_ready;
  assign owner_beat    = bus.req_write[bus.owner];
  assign bus.req_ready = rst ? '0 : ready;
  assign bus.owner_vld = state == LOCKED;
  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    idle_nxt    = idle_cnt;
    owner_nxt   = bus.owner;
    ready       = '0;
    load_beat   = '0;
    timeout_nxt = 1'b0;
    if (state == ARB) begin
      if (pick_vld && out_free) begin
        ready[pick_idx] = 1'b1;
        load_beat       = bus.req_write[pick_idx];
        if (load_beat.cycle_type == CYCLE_TYPE_VALID) begin
          state_nxt = LOCKED;
          owner_nxt = pick_idx;
          idle_nxt  = '0;
        end else begin
          rr_nxt = wrap_inc(pick_idx);
        end
      end
    end else if (owner_beat.cycle_type == CYCLE_TYPE_IDLE) begin
      // An idle owner is a legal bubble until it has idled TIMEOUT times in a row
      if (idle_cnt == CW'(TIMEOUT - 1)) begin
        state_nxt   = ARB;
        rr_nxt      = wrap_inc(bus.owner);
        idle_nxt    = '0;
        timeout_nxt = 1'b1;
      end else begin
        idle_nxt = idle_cnt + 1'b1;
      end
    end else if (out_free) begin
      ready[bus.owner] = 1'b1;
      load_beat        = owner_beat;
      idle_nxt         = '0;
      if (owner_beat.cycle_type == CYCLE_TYPE_DONE) begin
        state_nxt = ARB;
        rr_nxt    = wrap_inc(bus.owner);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ARB;
      rr_ptr          <= '0;
      idle_cnt        <= '0;
      bus.owner       <= '0;
      bus.out_write   <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      state           <= state_nxt;
      rr_ptr          <= rr_nxt;
      idle_cnt        <= idle_nxt;
      bus.owner       <= owner_nxt;
      bus.out_write   <= out_free ? load_beat : bus.out_write;
      bus.timeout_err <= timeout_nxt;
    end
  end
endmodule
